// File: rtl/reg_xfer_pkg.sv
// Shared types and constants for the register-transfer bus arbiter.
// Default sizes, FSM state encoding and transfer counter width.
package reg_xfer_pkg;

    localparam int CNT_W    = 8;
    localparam int DEF_NREQ = 4;
    localparam int DEF_NREG = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        LOAD
    } state_e;

endpackage

// File: rtl/reg_xfer_arb_if.sv
// Requester/register-bank side signals of the register-transfer arbiter.
// slave: arbiter view; master: requester/bench view.
interface reg_xfer_arb_if #(
    parameter int NREQ = reg_xfer_pkg::DEF_NREQ,
    parameter int NREG = reg_xfer_pkg::DEF_NREG
);

    localparam int SW = $clog2(NREG);

    logic [NREQ-1:0]                req;
    logic [NREQ*SW-1:0]             src;
    logic [NREQ*SW-1:0]             dst;
    logic [NREQ-1:0]                ack;
    logic                           err;
    logic [SW-1:0]                  bus_sel;
    logic [NREG-1:0]                load;
    logic                           busy;
    logic [reg_xfer_pkg::CNT_W-1:0] xfer_cnt;

    modport master (
        output req, src, dst,
        input  ack, err, bus_sel, load, busy, xfer_cnt
    );

    modport slave (
        input  req, src, dst,
        output ack, err, bus_sel, load, busy, xfer_cnt
    );

endinterface

// File: rtl/reg_xfer_arb_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or
// above ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    int idx;

    // Scan from the far end so the nearest requester is written last.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[IW'(idx)]) begin
                valid  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_xfer_arb.sv
// Round-robin arbiter/sequencer for the shared register-transfer bus.
// Optional transfer counter enabled by macro REG_XFER_CNT_EN.
module reg_xfer_arb
    import reg_xfer_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int NREG = DEF_NREG,
    localparam int SW   = $clog2(NREG),
    localparam int IW   = $clog2(NREQ)
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_xfer_arb_if.slave bus
);

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [SW-1:0]   src_q, src_d;
    logic [SW-1:0]   dst_q, dst_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [NREG-1:0] load_q, load_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [IW-1:0]   arb_win;
    logic            arb_vld;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req),
        .ptr   (ptr_q),
        .winner(arb_win),
        .valid (arb_vld)
    );

    // Outputs are computed one state ahead so every output is a flop.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        src_d   = src_q;
        dst_d   = dst_q;
        sel_d   = sel_q;
        load_d  = '0;
        ack_d   = '0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d = SETUP;
                    win_d   = arb_win;
                    src_d   = bus.src[int'(arb_win)*SW +: SW];
                    dst_d   = bus.dst[int'(arb_win)*SW +: SW];
                    sel_d   = src_d;
                    busy_d  = 1'b1;
                end
            end
            SETUP: begin
                state_d = LOAD;
                busy_d  = 1'b1;
                ack_d   = NREQ'(1) << win_q;
                if (src_q == dst_q) begin
                    err_d = 1'b1;
                end else begin
                    load_d = NREG'(1) << dst_q;
                end
            end
            LOAD: begin
                state_d = IDLE;
                ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            sel_q   <= '0;
            load_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            sel_q   <= sel_d;
            load_q  <= load_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.err     = err_q;
    assign bus.bus_sel = sel_q;
    assign bus.load    = load_q;
    assign bus.busy    = busy_q;

`ifdef REG_XFER_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts on entry to LOAD so the new value shows with the load pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == SETUP && src_q != dst_q) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.xfer_cnt = cnt_q;
`else
    assign bus.xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_xfer_arb.sv
// Directed bench for reg_xfer_arb (NREQ=4, NREG=4).
// Expected counter values follow REG_XFER_CNT_EN.
module tb_reg_xfer_arb;

    logic clk = 1'b0;
    logic rst_n;
    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;
    int   n;

    always #5 clk = ~clk;

    reg_xfer_arb_if #(.NREQ(4), .NREG(4)) bus ();

    reg_xfer_arb #(.NREQ(4), .NREG(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp();
`ifdef REG_XFER_CNT_EN
        return 32'(exp_cnt % 256);
`else
        return 32'd0;
`endif
    endfunction

    task automatic set_rq(input int i, input logic [1:0] s,
                          input logic [1:0] d);
        bus.src[i*2 +: 2] = s;
        bus.dst[i*2 +: 2] = d;
    endtask

    task automatic wait_ack(input int maxc, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (bus.ack == '0 && cyc < maxc);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ack"},  32'(bus.ack),  0);
        chk({tag, "_load"}, 32'(bus.load), 0);
        chk({tag, "_err"},  32'(bus.err),  0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        bus.req = '0;
        bus.src = '0;
        bus.dst = '0;
        step();
        step();
        chk_quiet("rst");
        chk("rst_sel", 32'(bus.bus_sel), 0);
        chk("rst_cnt", 32'(bus.xfer_cnt), 0);
        rst_n = 1'b1;
        step();
        chk_quiet("post_rst");

        // reset while a transfer sits in SETUP
        set_rq(0, 2'd1, 2'd2);
        bus.req = 4'b0001;
        step();
        chk("ms_busy", 32'(bus.busy), 1);
        chk("ms_sel", 32'(bus.bus_sel), 1);
        rst_n   = 1'b0;
        bus.req = '0;
        #1;
        chk_quiet("ms_rst");
        chk("ms_rst_sel", 32'(bus.bus_sel), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ms_after_ack", 32'(bus.ack), 0);
            chk("ms_after_load", 32'(bus.load), 0);
        end

        // full contention: grants 0,1,2,3 at cycles 2,5,8,11
        for (int i = 0; i < 4; i++) begin
            set_rq(i, 2'(i), 2'((i + 1) % 4));
        end
        bus.req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            wait_ack(6, n);
            chk("rr_lat", 32'(n), (g == 0) ? 2 : 3);
            chk("rr_ack", 32'(bus.ack), 32'(1) << g);
            chk("rr_load", 32'(bus.load), 32'(1) << ((g + 1) % 4));
            chk("rr_sel", 32'(bus.bus_sel), 32'(g));
            bus.req = bus.req & ~bus.ack;
            exp_cnt++;
        end
        step();

        // ptr wrapped to 0: req0 beats req3
        bus.req = 4'b1001;
        wait_ack(6, n);
        chk("w_ack0", 32'(bus.ack), 32'h1);
        bus.req = bus.req & ~bus.ack;
        exp_cnt++;
        wait_ack(6, n);
        chk("w_ack3", 32'(bus.ack), 32'h8);
        chk("w_lat3", 32'(n), 3);
        bus.req = '0;
        exp_cnt++;
        step();

        // single transfer, cycle by cycle
        set_rq(0, 2'd1, 2'd3);
        bus.req = 4'b0001;
        step();
        chk("s1_sel", 32'(bus.bus_sel), 1);
        chk("s1_busy", 32'(bus.busy), 1);
        chk("s1_load", 32'(bus.load), 0);
        chk("s1_ack", 32'(bus.ack), 0);
        step();
        chk("s2_load", 32'(bus.load), 32'h8);
        chk("s2_ack", 32'(bus.ack), 32'h1);
        chk("s2_err", 32'(bus.err), 0);
        chk("s2_busy", 32'(bus.busy), 1);
        chk("s2_sel", 32'(bus.bus_sel), 1);
        bus.req = '0;
        exp_cnt++;
        step();
        chk_quiet("s3");
        chk("s3_sel_hold", 32'(bus.bus_sel), 1);
        chk("s3_cnt", 32'(bus.xfer_cnt), cnt_exp());

        // src == dst: error, no load, count unchanged
        set_rq(2, 2'd2, 2'd2);
        bus.req = 4'b0100;
        step();
        chk("e1_sel", 32'(bus.bus_sel), 2);
        step();
        chk("e2_ack", 32'(bus.ack), 32'h4);
        chk("e2_err", 32'(bus.err), 1);
        chk("e2_load", 32'(bus.load), 0);
        bus.req = '0;
        step();
        chk_quiet("e3");
        chk("e3_cnt", 32'(bus.xfer_cnt), cnt_exp());

        // req1 held forever, req0 asserts once: 1,0,1
        set_rq(0, 2'd0, 2'd1);
        set_rq(1, 2'd1, 2'd2);
        bus.req = 4'b0010;
        wait_ack(6, n);
        chk("sv_ack1a", 32'(bus.ack), 32'h2);
        bus.req = 4'b0011;
        wait_ack(6, n);
        chk("sv_ack0", 32'(bus.ack), 32'h1);
        chk("sv_load0", 32'(bus.load), 32'h2);
        bus.req = 4'b0010;
        wait_ack(6, n);
        chk("sv_ack1b", 32'(bus.ack), 32'h2);
        chk("sv_lat1b", 32'(n), 3);
        bus.req = '0;
        step();

        // counter wrap: 300 transfers from reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("c_rst", 32'(bus.xfer_cnt), 0);
        exp_cnt = 0;
        set_rq(0, 2'd0, 2'd1);
        for (int i = 0; i < 300; i++) begin
            bus.req = 4'b0001;
            wait_ack(6, n);
            chk("c_ack", 32'(bus.ack), 32'h1);
            bus.req = '0;
            exp_cnt++;
            step();
        end
        chk("c_final", 32'(bus.xfer_cnt), cnt_exp());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_xfer_arb.md
# reg_xfer_arb

Round-robin arbiter and sequencer for the shared 4-bit register-transfer bus. Up to NREQ requesters each ask for a transfer "register src -> register dst"; the block grants one at a time, drives the bus source-mux select, then pulses the destination register's load enable for exactly one cycle. It sits between the requesting control logic and the bank of load-enabled 4-bit registers plus the bus mux, and is the only driver of their select and load lines.

## Interface
- NREQ, 4, number of requesters (2..8)
- NREG, 4, number of registers on the bus (power of two, 2..8)
- SW, $clog2(NREG), width of a register index
- clk  in  1  rising-edge clock, sole clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester transfer request, level
- src  in  NREQ*SW  packed source index, requester i at [i*SW +: SW]
- dst  in  NREQ*SW  packed destination index, same packing
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse with ack when src == dst (no load issued)
- bus_sel  out  SW  bus mux select (source register index)
- load  out  NREG  one-hot load enables to the registers
- busy  out  1  high in SETUP and LOAD
- xfer_cnt  out  8  completed-transfer count (see Configuration)

## Operation
- States: IDLE, SETUP, LOAD. All outputs registered.
- IDLE: if any req bit set, round-robin arbiter picks the lowest index at or above ptr (wrapping); latch winner id, src, dst; go SETUP. No req: stay IDLE.
- SETUP: bus_sel = latched src, load = 0; go LOAD. Gives the bus mux a full cycle to settle.
- LOAD: bus_sel held; load[dst] = 1 unless src == dst (then load = 0, err = 1); ack[winner] = 1; ptr <= winner+1 mod NREQ; go IDLE.
- Granted src/dst are latched at grant; later changes or dropping req do not affect the transfer in flight; it always completes.
- Requester must deassert req in the cycle after ack or it is re-arbitrated as a new request (still behind other requesters due to ptr advance).
- load is at most one-hot; never asserted outside LOAD.
- bus_sel in IDLE holds its last value (reset 0).
- Reset (any state, any time): state IDLE, ptr 0, ack 0, err 0, load 0, bus_sel 0, busy 0, xfer_cnt 0. A transfer interrupted by reset is lost; no load is issued.

## Timing
- Request seen at edge T (state IDLE) -> SETUP in cycle T+1 -> LOAD/ack/err in cycle T+2 -> destination register captures bus at edge ending T+2 -> IDLE at T+3.
- Throughput: one transfer per 3 cycles; no back-to-back overlap.
- Latency from req to ack: 2 cycles when idle; up to 3*(NREQ-1)+2 cycles under full contention.
- Simultaneous requests: resolved in one IDLE cycle by round-robin; starvation-free.
- xfer_cnt increments in the LOAD cycle for non-error transfers, wraps 255 -> 0.

## Configuration
- Macro REG_XFER_CNT_EN.
- Defined: 8-bit xfer_cnt counter implemented as above.
- Undefined: counter logic omitted; xfer_cnt tied to 8'd0.

## Structure
- Package reg_xfer_pkg: state enum (IDLE, SETUP, LOAD), counter width constant 8, default NREQ/NREG.
- Sub-module rr_arbiter: combinational round-robin pick from req vector and ptr, outputs winner index and valid; ptr register lives in reg_xfer_arb.

## Test plan
- Reset mid-SETUP after single req (src 1, dst 2) -> load stays 0, ack never pulses, all outputs 0, state IDLE.
- Single req0 src 1 dst 3 at cycle 0 -> bus_sel=1 from cycle 1, load=4'b1000 and ack=4'b0001 in cycle 2, busy high cycles 1-2, xfer_cnt=1.
- req=4'b1111 held, each dropping after ack -> grants in order 0,1,2,3 at acks in cycles 2,5,8,11; next new req3+req0 -> req0 granted (ptr=0).
- req2 with src 2 dst 2 -> ack[2] and err in cycle 2, load=0, xfer_cnt unchanged.
- req1 held permanently, req0 asserts once -> grants alternate 1,0,1: no starvation.
- Without REG_XFER_CNT_EN, 300 transfers -> xfer_cnt constant 0; with it, value 44 (300 mod 256).
